// File: rtl/rng_address_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rng_pkg
// Brief   : Shared constants, state encoding and LFSR step for rng_address_gen
// Revision: 1.0
// ============================================================================
package rng_pkg;

    localparam int          c_WORD_WIDTH   = 16;
    localparam logic [15:0] c_DEFAULT_SEED = 16'hACE1;

    localparam int c_TAP_A = 15;
    localparam int c_TAP_B = 13;
    localparam int c_TAP_C = 12;
    localparam int c_TAP_D = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        logic w_fb;
        w_fb = q[c_TAP_A] ^ q[c_TAP_B] ^ q[c_TAP_C] ^ q[c_TAP_D];
        return {q[14:0], w_fb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rng_address_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : rng_address_gen_if
// Brief   : Four-phase random-neighbour-address request/response bundle
// Revision: 1.0
// ============================================================================
interface rng_address_gen_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  start_rngAddress;
    logic [WORD_WIDTH-1:0] betterNeighborCount;
    logic [WORD_WIDTH-1:0] rng_address;
    logic                  done_rng_address;
    logic                  busy;
    logic                  zero_count;

    modport master (
        output start_rngAddress,
        output betterNeighborCount,
        input  rng_address,
        input  done_rng_address,
        input  busy,
        input  zero_count
    );

    modport slave (
        input  start_rngAddress,
        input  betterNeighborCount,
        output rng_address,
        output done_rng_address,
        output busy,
        output zero_count
    );
endinterface
`default_nettype wire

// File: rtl/rng_address_gen_lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : lfsr16
// Brief   : 16-bit Fibonacci LFSR with advance enable; zero seed maps to default
// Revision: 1.0
// ============================================================================
module lfsr16
    import rng_pkg::*;
#(
    parameter logic [15:0] SEED = c_DEFAULT_SEED
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_advance,
    output logic [15:0]      o_q,
    output logic [15:0]      o_q_next
);
    // An all-zero state would lock up the register.
    localparam logic [15:0] c_SEED_EFF = (SEED == 16'h0000) ? c_DEFAULT_SEED : SEED;

    logic [15:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= c_SEED_EFF;
        end else if (i_advance) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign o_q      = r_q;
    assign o_q_next = lfsr_next(r_q);
endmodule
`default_nettype wire

// File: rtl/rng_address_gen.sv
`default_nettype none
// ============================================================================
// Module  : rng_address_gen
// Brief   : LFSR index generator reduced modulo a count by a bit-serial divider
// Revision: 1.0
// ============================================================================
module rng_address_gen
    import rng_pkg::*;
#(
    parameter int          WORD_WIDTH = c_WORD_WIDTH,
    parameter logic [15:0] SEED       = c_DEFAULT_SEED
) (
    input  wire logic          clock,
    input  wire logic          reset,
    rng_address_gen_if.slave   bus
);
    localparam int c_BIT_W = $clog2(WORD_WIDTH);

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_count;
    logic [WORD_WIDTH:0]   r_rem;
    logic [c_BIT_W-1:0]    r_bit;
    logic [WORD_WIDTH-1:0] r_address;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_zero;

    logic                  w_advance;
    logic [15:0]           w_lfsr_q;
    logic [15:0]           w_unused_q_next;
    logic [WORD_WIDTH-1:0] w_dividend;
    logic [WORD_WIDTH:0]   w_shift;
    logic [WORD_WIDTH:0]   w_rem_next;

    assign w_advance = (r_state == ST_IDLE) && bus.start_rngAddress && !r_done;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clock),
        .rst       (reset),
        .i_advance (w_advance),
        .o_q       (w_lfsr_q),
        .o_q_next  (w_unused_q_next)
    );

    // The LFSR is frozen during DIV, so its current value is the dividend.
    assign w_dividend = WORD_WIDTH'(w_lfsr_q);
    assign w_shift    = {r_rem[WORD_WIDTH-1:0], w_dividend[r_bit]};
    assign w_rem_next = (w_shift >= {1'b0, r_count}) ? (w_shift - {1'b0, r_count}) : w_shift;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_bit     <= '0;
            r_address <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_rngAddress && !r_done) begin
                        r_count <= bus.betterNeighborCount;
                        r_rem   <= '0;
                        r_bit   <= c_BIT_W'(WORD_WIDTH - 1);
                        if (bus.betterNeighborCount == '0) begin
                            r_address <= '0;
                            r_zero    <= 1'b1;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= ST_DONE;
                        end else begin
                            r_zero    <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_next;
                    if (r_bit == '0) begin
                        r_address <= w_rem_next[WORD_WIDTH-1:0];
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_bit <= r_bit - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!bus.start_rngAddress) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rng_address      = r_address;
    assign bus.done_rng_address = r_done;
    assign bus.busy             = r_busy;
    assign bus.zero_count       = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_rng_address_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_rng_address_gen
// Brief   : Directed and random scoreboard bench for rng_address_gen
// Revision: 1.0
// ============================================================================
module tb_rng_address_gen;

    typedef struct packed {
        logic [15:0] addr;
        logic        zero;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rng_address_gen_if #(.WORD_WIDTH(16)) bus ();

    rng_address_gen #(
        .WORD_WIDTH (16),
        .SEED       (16'hACE1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    exp_t        last_exp;
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] model_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_request(input logic [15:0] cnt);
        exp_t e;
        m_lfsr = model_next(m_lfsr);
        e.addr = (cnt == 16'd0) ? 16'd0 : (m_lfsr % cnt);
        e.zero = (cnt == 16'd0);
        sb.push_back(e);
        bus.betterNeighborCount = cnt;
        bus.start_rngAddress    = 1'b1;
    endtask

    // exp_cycles counts sampled edges from the accepting edge through the one that raises done
    task automatic await_result(input string tag, input int exp_cycles, input bit glitch);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (cyc == 1) check({tag, "_busy_after_accept"}, 32'(bus.busy), 32'(exp_cycles > 1));
            if (glitch) begin
                if (cyc == 3) bus.betterNeighborCount = 16'd1;
                if (cyc == 5) bus.start_rngAddress = 1'b0;
                if (cyc == 6) bus.start_rngAddress = 1'b1;
            end
        end while (!bus.done_rng_address && cyc < 40);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_cycles));
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            last_exp = sb.pop_front();
            check({tag, "_addr"}, 32'(bus.rng_address), 32'(last_exp.addr));
            check({tag, "_zero"}, 32'(bus.zero_count), 32'(last_exp.zero));
            check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic release_start(input string tag);
        bus.start_rngAddress = 1'b0;
        tick();
        check({tag, "_done_fall"}, 32'(bus.done_rng_address), 32'd0);
        check({tag, "_addr_hold"}, 32'(bus.rng_address), 32'(last_exp.addr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rst_addr"}, 32'(bus.rng_address), 32'd0);
        check({tag, "_rst_done"}, 32'(bus.done_rng_address), 32'd0);
        check({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_rst_zero"}, 32'(bus.zero_count), 32'd0);
    endtask

    task automatic fresh_reset();
        reset = 1'b1;
        bus.start_rngAddress = 1'b0;
        m_lfsr = 16'hACE1;
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] c;
        bus.start_rngAddress    = 1'b0;
        bus.betterNeighborCount = 16'd0;
        m_lfsr                  = 16'hACE1;
        last_exp                = '0;

        repeat (3) tick();
        check_reset_outputs("init");
        reset = 1'b0;
        tick();

        // Count 5 from seed: LFSR 0x59C3 -> 4
        drive_request(16'd5);
        await_result("t1", 17, 1'b0);
        check("t1_direct", 32'(bus.rng_address), 32'd4);
        release_start("t1");

        // Count 7 then 5 after fresh reset
        fresh_reset();
        drive_request(16'd7);
        await_result("t2a", 17, 1'b0);
        check("t2a_direct", 32'(bus.rng_address), 32'd5);
        release_start("t2a");
        drive_request(16'd5);
        await_result("t2b", 17, 1'b0);
        check("t2b_direct", 32'(bus.rng_address), 32'd4);
        release_start("t2b");

        // Zero count still advances the LFSR
        fresh_reset();
        drive_request(16'd0);
        await_result("t3a", 1, 1'b0);
        release_start("t3a");
        drive_request(16'd5);
        await_result("t3b", 17, 1'b0);
        check("t3b_direct", 32'(bus.rng_address), 32'd4);
        release_start("t3b");

        // Count and start disturbed during DIV
        fresh_reset();
        drive_request(16'd5);
        await_result("t4", 17, 1'b1);
        check("t4_direct", 32'(bus.rng_address), 32'd4);
        release_start("t4");
        repeat (3) begin
            tick();
            check("t4_no_extra_done", 32'(bus.done_rng_address), 32'd0);
            check("t4_no_extra_busy", 32'(bus.busy), 32'd0);
        end

        // Start held high through DONE
        drive_request(16'd9);
        await_result("t5a", 17, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold_done", 32'(bus.done_rng_address), 32'd1);
            check("t5_hold_addr", 32'(bus.rng_address), 32'(last_exp.addr));
            check("t5_hold_busy", 32'(bus.busy), 32'd0);
        end
        release_start("t5a");
        drive_request(16'd3);
        await_result("t5b", 17, 1'b0);
        release_start("t5b");

        // Reset in the middle of a division
        bus.betterNeighborCount = 16'd5;
        bus.start_rngAddress    = 1'b1;
        repeat (8) tick();
        check("t6_busy_mid_div", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("t6");
        bus.start_rngAddress = 1'b0;
        m_lfsr = 16'hACE1;
        tick();
        reset = 1'b0;
        tick();
        drive_request(16'd5);
        await_result("t6", 17, 1'b0);
        check("t6_direct", 32'(bus.rng_address), 32'd4);
        release_start("t6");

        // Random nonzero counts
        for (int k = 0; k < 20; k++) begin
            c = 16'($urandom_range(1, 65535));
            drive_request(c);
            await_result("rnd", 17, 1'b0);
            check("rnd_below_count", 32'(bus.rng_address < c), 32'd1);
            release_start("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
